apb4_master_bridge: RTL

//  APB4 initiator: turns a valid/ready request/response port into APB4 SETUP/ACCESS transfers.

---
 rtl/apb4_mst_pkg.sv | 14 +
 rtl/apb4_mst_wdog.sv | 30 +++
 rtl/apb4_master_bridge.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/apb4_mst_pkg.sv
// Shared types and field widths for the APB4 master bridge.
package apb4_mst_pkg;

  localparam int APB4_STRB_W = 4;
  localparam int APB4_PROT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb4_mst_state_e;

endpackage

// File: rtl/apb4_mst_wdog.sv
// ACCESS-phase wait-state watchdog. Expires on the LIMIT-th consecutive
// enabled cycle; only instantiated when APB4_MST_TIMEOUT_EN is defined.
module apb4_mst_wdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic hclk,
  input  logic hresetn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;

  // The cycle that would take the count to LIMIT is the expiry cycle itself.
  assign expired_o = enable_i && (count_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/apb4_master_bridge.sv
// APB4 initiator bridging a valid/ready request/response port onto APB4.
// Optional ACCESS-phase timeout enabled by defining APB4_MST_TIMEOUT_EN.
module apb4_master_bridge
  import apb4_mst_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [DATA_WIDTH-1:0]  req_wdata_i,
  input  logic [APB4_STRB_W-1:0] req_strb_i,
  input  logic [APB4_PROT_W-1:0] req_prot_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DATA_WIDTH-1:0]  rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic [ADDR_WIDTH-1:0]  paddr_o,
  output logic [APB4_PROT_W-1:0] pprot_o,
  output logic                   pwrite_o,
  output logic [DATA_WIDTH-1:0]  pwdata_o,
  output logic [APB4_STRB_W-1:0] pstrb_o,
  output logic                   psel_o,
  output logic                   penable_o,
  input  logic                   pready_i,
  input  logic [DATA_WIDTH-1:0]  prdata_i,
  input  logic                   pslverr_i
);

  apb4_mst_state_e state_q, state_d;

  logic                   ready_q, ready_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   write_q, write_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [APB4_STRB_W-1:0] strb_q, strb_d;
  logic [APB4_PROT_W-1:0] prot_q, prot_d;

  logic accept;
  logic expired;

  // ready_q is only ever set while in IDLE, so it alone qualifies acceptance.
  assign accept = req_valid_i && ready_q;

`ifdef APB4_MST_TIMEOUT_EN
  apb4_mst_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .clear_i   (accept),
    .enable_i  ((state_q == ACCESS) && !pready_i),
    .expired_o (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // NOTE: every signal gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prot_d    = prot_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          write_d = req_write_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          strb_d  = req_write_i ? req_strb_i : '0;
          prot_d  = req_prot_i;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          state_d = RESP;
          rdata_d = write_q ? '0 : prdata_i;
          err_d   = pslverr_i;
        end else if (expired) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bus/handshake outputs are registered from the next state.
    ready_d     = (state_d == IDLE);
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      prot_q      <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      prot_q      <= prot_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign paddr_o     = addr_q;
  assign pprot_o     = prot_q;
  assign pwrite_o    = write_q;
  assign pwdata_o    = wdata_q;
  assign pstrb_o     = strb_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;

endmodule
